brg_xcel_master_arb: RTL and testbench
======================================

BRG_XCEL_MASTER_ARB -- requirements
Module: brg_xcel_master_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of accelerator master requesters (2..4).
REQ-002 SHALL have parameter addr_width_p, default 32, request address width.
REQ-003 SHALL have parameter data_width_p, default 32, request/return data width; mask width is data_width_p/8.
REQ-004 SHALL have parameter load_id_width_p, default 11, endpoint opaque/load-id width; idx_w = clog2(num_req_p); requester opaque width ow = load_id_width_p - idx_w.
REQ-005 SHALL have parameter max_out_p, default 8, maximum outstanding loads per requester.
REQ-006 SHALL have clk_i, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have reset_n_i, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have req_v_i, input, num_req_p, per-requester request valid.
REQ-009 SHALL have req_type_i, input, num_req_p, per-requester type (1 = store, 0 = load).
REQ-010 SHALL have req_addr_i / req_data_i / req_mask_i, input, num_req_p x addr/data/mask widths, packed, requester k at slice k.
REQ-011 SHALL have req_opq_i, input, num_req_p*ow, per-requester load opaque.
REQ-012 SHALL have req_rdy_o, output, num_req_p, per-requester accept; transfer when req_v_i[k] & req_rdy_o[k].
REQ-013 SHALL have out_v_o, out_type_o, out_addr_o, out_data_o, out_mask_o, out_opq_o (load_id_width_p), outputs, toward endpoint master port.
REQ-014 SHALL have out_rdy_i, input, 1, endpoint ready; transfer when out_v_o & out_rdy_i.
REQ-015 SHALL have ret_v_i, ret_opq_i (load_id_width_p), ret_data_i (data_width_p), inputs, endpoint load return; always accepted.
REQ-016 SHALL have ret_v_o (num_req_p), ret_opq_o (ow), ret_data_o (data_width_p), outputs, routed return to requesters.
REQ-017 SHALL have busy_o, output, 1, high when any outstanding counter is nonzero; err_o, output, 1, sticky protocol error.

Function
REQ-018 Requester k SHALL be eligible when req_v_i[k] & (req_type_i[k] | out_cnt[k] < max_out_p).
REQ-019 Arbitration SHALL be round-robin: grant lowest eligible index at or above rr_ptr, wrapping to 0; combinational, same-cycle.
REQ-020 out_v_o SHALL be 1 iff any requester is eligible; out_* fields SHALL mux the granted requester; out_v_o SHALL NOT depend on out_rdy_i.
REQ-021 out_opq_o SHALL equal {grant index (idx_w bits), req_opq_i[k]} for loads and 0 for stores.
REQ-022 req_rdy_o[k] SHALL be 1 only for the granted k and only when out_rdy_i = 1; at most one bit set.
REQ-023 On a transfer, rr_ptr SHALL update to (grant+1) mod num_req_p; otherwise rr_ptr SHALL hold (no starvation under held requests).
REQ-024 out_cnt[k] (width clog2(max_out_p+1)) SHALL increment on a load transfer from k and decrement on a routed return to k; both same cycle: unchanged.
REQ-025 A load from k at out_cnt[k] = max_out_p SHALL NOT be granted; stores from k remain eligible.
REQ-026 Returns SHALL be registered: one cycle after ret_v_i, ret_v_o[ret_opq_i upper idx_w bits] = 1 for one cycle, ret_opq_o/ret_data_o = lower bits/data.
REQ-027 A return whose index >= num_req_p or whose target out_cnt is 0 SHALL be dropped (no ret_v_o, no counter change) and SHALL set err_o until reset.
REQ-028 Back-to-back returns SHALL be delivered every cycle with no bubbles.

Reset
REQ-029 When reset_n_i = 0 at a rising edge: rr_ptr = 0, all out_cnt = 0, ret_v_o = 0, ret_opq_o = 0, ret_data_o = 0, err_o = 0.
REQ-030 During reset combinational outputs SHALL be forced: out_v_o = 0, req_rdy_o = 0; ret_v_i SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard all outstanding-load state; returns in the reset cycle are dropped without setting err_o.

Verification
REQ-032 Both requesters hold loads, out_rdy_i = 1 continuously -> grants alternate 0,1,0,1; out_opq_o MSB matches grant.
REQ-033 Requester 0 issues 8 loads, no returns -> 9th load not granted, requester 1 store still granted; one return to 0 -> load granted next cycle.
REQ-034 ret_v_i with ret_opq_i = {1, 10'h2A}, data 32'hDEADBEEF -> next cycle ret_v_o = 2'b10, ret_opq_o = 10'h2A, ret_data_o = 32'hDEADBEEF, out_cnt[1] - 1.
REQ-035 Load issue and return for requester 0 in same cycle at out_cnt = 3 -> out_cnt stays 3, busy_o = 1.
REQ-036 Return to requester 1 with out_cnt[1] = 0 -> no ret_v_o, err_o = 1 and stays until reset_n_i low.
REQ-037 out_rdy_i = 0 for 5 cycles with requests held -> out_v_o = 1, req_rdy_o = 0, rr_ptr unchanged; reset asserted mid-run -> all counters 0, out_v_o = 0.

Source files
------------

// File: rtl/brg_xcel_master_arb.sv
// Round-robin arbiter merging accelerator master requests onto one endpoint port,
// tracking outstanding loads per requester and routing load returns back by opaque index.
module brg_xcel_master_arb #(
    parameter int num_req_p       = 2,
    parameter int addr_width_p    = 32,
    parameter int data_width_p    = 32,
    parameter int load_id_width_p = 11,
    parameter int max_out_p       = 8,
    localparam int idx_w = $clog2(num_req_p),
    localparam int ow    = load_id_width_p - idx_w,
    localparam int mw    = data_width_p / 8,
    localparam int cnt_w = $clog2(max_out_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_type_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p*mw-1:0]           req_mask_i,
    input  logic [num_req_p*ow-1:0]           req_opq_i,
    output logic [num_req_p-1:0]              req_rdy_o,
    output logic                              out_v_o,
    output logic                              out_type_o,
    output logic [addr_width_p-1:0]           out_addr_o,
    output logic [data_width_p-1:0]           out_data_o,
    output logic [mw-1:0]                     out_mask_o,
    output logic [load_id_width_p-1:0]        out_opq_o,
    input  logic                              out_rdy_i,
    input  logic                              ret_v_i,
    input  logic [load_id_width_p-1:0]        ret_opq_i,
    input  logic [data_width_p-1:0]           ret_data_i,
    output logic [num_req_p-1:0]              ret_v_o,
    output logic [ow-1:0]                     ret_opq_o,
    output logic [data_width_p-1:0]           ret_data_o,
    output logic                              busy_o,
    output logic                              err_o
);

    logic [num_req_p-1:0][addr_width_p-1:0] addr_a;
    logic [num_req_p-1:0][data_width_p-1:0] data_a;
    logic [num_req_p-1:0][mw-1:0]           mask_a;
    logic [num_req_p-1:0][ow-1:0]           opq_a;

    assign addr_a = req_addr_i;
    assign data_a = req_data_i;
    assign mask_a = req_mask_i;
    assign opq_a  = req_opq_i;

    logic [idx_w-1:0]                rr_q, rr_d;
    logic [num_req_p-1:0][cnt_w-1:0] cnt_q, cnt_d;
    logic [num_req_p-1:0]            ret_v_q, ret_v_d;
    logic [ow-1:0]                   ret_opq_q, ret_opq_d;
    logic [data_width_p-1:0]         ret_data_q, ret_data_d;
    logic                            err_q, err_d;

    logic [num_req_p-1:0] elig;
    logic                 gnt_found;
    logic [idx_w-1:0]     gnt_idx;
    logic [idx_w-1:0]     cand;
    logic                 xfer;
    logic [idx_w-1:0]     ret_idx;
    logic                 ret_ok;
    logic                 inc, dec;

    // Eligibility and round-robin search starting at rr_q.
    always_comb begin
        elig      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < num_req_p; k++) begin
            elig[k] = req_v_i[k] & (req_type_i[k] | (cnt_q[k] < cnt_w'(max_out_p)));
        end
        for (int i = 0; i < num_req_p; i++) begin
            cand = idx_w'((int'(rr_q) + i) % num_req_p);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        out_v_o    = reset_n_i & gnt_found;
        out_type_o = req_type_i[gnt_idx];
        out_addr_o = addr_a[gnt_idx];
        out_data_o = data_a[gnt_idx];
        out_mask_o = mask_a[gnt_idx];
        out_opq_o  = req_type_i[gnt_idx] ? '0 : {gnt_idx, opq_a[gnt_idx]};
        xfer       = out_v_o & out_rdy_i;
        req_rdy_o  = '0;
        if (xfer) req_rdy_o[gnt_idx] = 1'b1;
    end

    // Returns are accepted only for a real requester with a load in flight.
    always_comb begin
        ret_idx    = ret_opq_i[load_id_width_p-1 -: idx_w];
        ret_ok     = ret_v_i && (int'(ret_idx) < num_req_p) && (cnt_q[ret_idx] != '0);
        ret_v_d    = '0;
        if (ret_ok) ret_v_d[ret_idx] = 1'b1;
        ret_opq_d  = ret_ok ? ret_opq_i[ow-1:0] : ret_opq_q;
        ret_data_d = ret_ok ? ret_data_i : ret_data_q;
        err_d      = err_q | (ret_v_i & ~ret_ok);
        rr_d       = rr_q;
        if (xfer) rr_d = (int'(gnt_idx) == num_req_p - 1) ? '0 : gnt_idx + 1'b1;
        cnt_d      = cnt_q;
        inc        = 1'b0;
        dec        = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            inc = xfer & ~req_type_i[k] & (int'(gnt_idx) == k);
            dec = ret_ok & (int'(ret_idx) == k);
            if (inc && !dec)      cnt_d[k] = cnt_q[k] + cnt_w'(1);
            else if (dec && !inc) cnt_d[k] = cnt_q[k] - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_q       <= '0;
            cnt_q      <= '0;
            ret_v_q    <= '0;
            ret_opq_q  <= '0;
            ret_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            ret_v_q    <= ret_v_d;
            ret_opq_q  <= ret_opq_d;
            ret_data_q <= ret_data_d;
            err_q      <= err_d;
        end
    end

    assign ret_v_o    = ret_v_q;
    assign ret_opq_o  = ret_opq_q;
    assign ret_data_o = ret_data_q;
    assign busy_o     = |cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_brg_xcel_master_arb.sv
// Bench for brg_xcel_master_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a count/pointer model.
module tb_brg_xcel_master_arb;
    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LID = 11;
    localparam int MO  = 8;
    localparam int IW  = $clog2(N);
    localparam int OW  = LID - IW;
    localparam int MW  = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_v, req_type, req_rdy;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*MW-1:0] req_mask;
    logic [N*OW-1:0] req_opq;
    logic            out_v, out_type, out_rdy;
    logic [AW-1:0]   out_addr;
    logic [DW-1:0]   out_data;
    logic [MW-1:0]   out_mask;
    logic [LID-1:0]  out_opq;
    logic            ret_v;
    logic [LID-1:0]  ret_opq;
    logic [DW-1:0]   ret_data;
    logic [N-1:0]    ret_v_o;
    logic [OW-1:0]   ret_opq_o;
    logic [DW-1:0]   ret_data_o;
    logic            busy, err;

    brg_xcel_master_arb #(
        .num_req_p(N), .addr_width_p(AW), .data_width_p(DW),
        .load_id_width_p(LID), .max_out_p(MO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_type_i(req_type), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_mask_i(req_mask), .req_opq_i(req_opq),
        .req_rdy_o(req_rdy),
        .out_v_o(out_v), .out_type_o(out_type), .out_addr_o(out_addr),
        .out_data_o(out_data), .out_mask_o(out_mask), .out_opq_o(out_opq),
        .out_rdy_i(out_rdy),
        .ret_v_i(ret_v), .ret_opq_i(ret_opq), .ret_data_i(ret_data),
        .ret_v_o(ret_v_o), .ret_opq_o(ret_opq_o), .ret_data_o(ret_data_o),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: outstanding counts, pointer, sticky error, registered return.
    int            m_cnt [N];
    int            m_rr;
    bit            m_err;
    logic [N-1:0]  m_rv;
    logic [OW-1:0] m_ropq;
    logic [DW-1:0] m_rdata;
    bit            armed = 0;

    function automatic int model_grant();
        for (int i = 0; i < N; i++) begin
            int k = (m_rr + i) % N;
            if (req_v[k] && (req_type[k] || m_cnt[k] < MO)) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_rr = 0; m_err = 0; m_rv = '0; m_ropq = '0; m_rdata = '0;
            armed = 1;
        end else begin
            int g, ri;
            g  = model_grant();
            ri = int'(ret_opq) >> OW;
            m_rv = '0;
            if (ret_v) begin
                if (ri < N && m_cnt[ri] > 0) begin
                    m_cnt[ri]--;
                    m_rv[ri] = 1'b1;
                    m_ropq   = ret_opq[OW-1:0];
                    m_rdata  = ret_data;
                end else m_err = 1;
            end
            if (g >= 0 && out_rdy) begin
                if (!req_type[g]) m_cnt[g]++;
                m_rr = (g + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            int g;
            bit ev, eb;
            logic [N-1:0]   erdy;
            logic [LID-1:0] eopq;
            g  = model_grant();
            ev = rst_n && g >= 0;
            erdy = '0;
            if (ev && out_rdy) erdy[g] = 1'b1;
            chk("out_v", out_v, ev);
            chk("req_rdy", req_rdy, erdy);
            if (ev) begin
                eopq = '0;
                if (!req_type[g]) begin
                    eopq[OW-1:0]  = req_opq[g*OW +: OW];
                    eopq[LID-1:OW] = IW'(g);
                end
                chk("out_type", out_type, req_type[g]);
                chk("out_addr", out_addr, req_addr[g*AW +: AW]);
                chk("out_data", out_data, req_data[g*DW +: DW]);
                chk("out_mask", out_mask, req_mask[g*MW +: MW]);
                chk("out_opq", out_opq, eopq);
            end
            eb = 0;
            foreach (m_cnt[k]) if (m_cnt[k] != 0) eb = 1;
            chk("ret_v_o", ret_v_o, m_rv);
            chk("ret_opq_o", ret_opq_o, m_ropq);
            chk("ret_data_o", ret_data_o, m_rdata);
            chk("busy", busy, eb);
            chk("err", err, m_err);
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); endtask

    task automatic idle();
        req_v = '0; req_type = '0; out_rdy = 1'b0; ret_v = 1'b0;
        ret_opq = '0; ret_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_v = '1; req_type = '0; out_rdy = 1'b1;
        mid();
        chk("rst out_v", out_v, 1'b0);
        chk("rst req_rdy", req_rdy, '0);
        tick(); tick();
        rst_n = 1'b1; idle();
        mid();
        chk("post-rst busy", busy, 1'b0);
        chk("post-rst err", err, 1'b0);
        chk("post-rst ret_v", ret_v_o, '0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; idle();
        req_addr = '0; req_data = '0; req_mask = '0; req_opq = '0;
        tick();
        do_reset();

        // Alternating grants with both requesters holding loads.
        req_addr = {32'hA1, 32'hA0}; req_opq = {10'h11, 10'h10};
        req_v = 2'b11; req_type = 2'b00; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("alt rdy", req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt opq msb", out_opq[LID-1], i % 2);
            tick();
        end

        // Outstanding limit blocks loads, not stores; one return reopens.
        do_reset();
        req_v = 2'b01; req_type = 2'b00; out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mid(); chk("fill rdy", req_rdy, 2'b01); tick();
        end
        req_v = 2'b11; req_type = 2'b10;
        mid();
        chk("store v", out_v, 1'b1);
        chk("store rdy", req_rdy, 2'b10);
        chk("store opq", out_opq, '0);
        tick();
        req_v = 2'b01; req_type = 2'b00;
        ret_v = 1'b1; ret_opq = {1'b0, 10'h005}; ret_data = 32'h1234;
        mid(); chk("full v", out_v, 1'b0);
        tick();
        ret_v = 1'b0;
        mid();
        chk("reopen rdy", req_rdy, 2'b01);
        chk("reopen ret_v", ret_v_o, 2'b01);
        tick(); idle();

        // Routed return to requester 1.
        do_reset();
        req_v = 2'b10; req_type = 2'b00; out_rdy = 1'b1; req_opq = {10'h2A, 10'h0};
        mid(); chk("r1 load", req_rdy, 2'b10); tick(); idle();
        ret_v = 1'b1; ret_opq = {1'b1, 10'h2A}; ret_data = 32'hDEADBEEF;
        tick(); ret_v = 1'b0;
        mid();
        chk("ret v", ret_v_o, 2'b10);
        chk("ret opq", ret_opq_o, 10'h2A);
        chk("ret data", ret_data_o, 32'hDEADBEEF);
        chk("ret busy", busy, 1'b0);
        tick();
        mid(); chk("ret pulse", ret_v_o, 2'b00);
        tick();

        // Same-cycle issue and return leaves count at 3.
        do_reset();
        req_v = 2'b01; req_type = 2'b00; out_rdy = 1'b1;
        tick(); tick(); tick();
        ret_v = 1'b1; ret_opq = {1'b0, 10'h1}; ret_data = 32'h55;
        tick(); ret_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mid();
            if (i == 0) chk("same busy", busy, 1'b1);
            chk("same cap", out_v, i < 5);
            tick();
        end
        idle();

        // Stray return sets sticky error.
        do_reset();
        ret_v = 1'b1; ret_opq = {1'b1, 10'h3}; ret_data = 32'h77;
        tick(); ret_v = 1'b0;
        mid();
        chk("stray ret_v", ret_v_o, 2'b00);
        chk("stray err", err, 1'b1);
        tick(); tick(); tick();
        mid(); chk("err sticky", err, 1'b1);
        tick();
        do_reset();

        // Backpressure holds pointer; reset mid-run clears state.
        req_v = 2'b11; req_type = 2'b00; out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("bp v", out_v, 1'b1);
            chk("bp rdy", req_rdy, 2'b00);
            chk("bp ptr", out_opq[LID-1], 1'b0);
            tick();
        end
        out_rdy = 1'b1;
        mid(); chk("bp release", req_rdy, 2'b01);
        tick();
        rst_n = 1'b0;
        mid(); chk("midrst v", out_v, 1'b0);
        tick();
        rst_n = 1'b1; out_rdy = 1'b0;
        mid();
        chk("midrst busy", busy, 1'b0);
        chk("midrst ptr", out_opq[LID-1], 1'b0);
        tick(); idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            int k;
            rst_n    = ($urandom_range(0, 80) != 0);
            req_v    = N'($urandom);
            req_type = N'($urandom);
            req_addr = {$urandom, $urandom};
            req_data = {$urandom, $urandom};
            req_mask = N*MW'($urandom);
            req_opq  = N*OW'($urandom);
            out_rdy  = ($urandom_range(0, 3) != 0);
            ret_v    = 1'b0;
            ret_data = $urandom;
            k = $urandom_range(0, N - 1);
            ret_opq  = {IW'(k), OW'($urandom)};
            if ($urandom_range(0, 1) == 1 && (m_cnt[k] > 0 || $urandom_range(0, 15) == 0))
                ret_v = 1'b1;
            tick();
        end
        idle();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
